// File: rtl/hi_speed_sampler_s_axi_regs.sv
// AXI4-Lite register file for the hi-speed sampler: NUM_REGS RW words,
// byte strobes, SLVERR on unmapped words, per-register write pulses.
// Ports: ACLK/ARESET (sync, active-high); S_AXI_* AXI4-Lite responder;
// reg_out = flattened registers; reg_wr_stb = one-cycle update pulses.
module hi_speed_sampler_s_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]             reg_wr_stb
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IW:0] NREG = (IW+1)'(NUM_REGS);

  typedef enum logic {WR_IDLE, WR_RESP} wr_st_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_st_t;

  wr_st_t r_wst, w_wst_nxt;
  rd_st_t r_rst, w_rst_nxt;

  logic [DW-1:0]       r_regs [NUM_REGS];
  logic                r_aw_cap, r_w_cap;
  logic [IW-1:0]       r_awidx;
  logic [DW-1:0]       r_wdata;
  logic [NB-1:0]       r_wstrb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [1:0]          r_rresp;
  logic [DW-1:0]       r_rdata;
  logic [NUM_REGS-1:0] r_wr_stb;

  logic          w_awready, w_wready, w_arready;
  logic          w_commit, w_bdone, w_ar_acc;
  logic [IW-1:0] w_awidx, w_aridx;
  logic          w_widx_ok, w_ridx_ok;
  logic [DW-1:0] w_rd_word;
  logic          w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_awidx   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_aridx   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_widx_ok = {1'b0, r_awidx} < NREG;
  assign w_ridx_ok = {1'b0, w_aridx} < NREG;

  // Write FSM: commit fires the cycle after both halves are captured.
  always_comb begin
    w_wst_nxt = r_wst;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_commit  = 1'b0;
    w_bdone   = 1'b0;
    unique case (r_wst)
      WR_IDLE: begin
        w_awready = !r_aw_cap && !ARESET;
        w_wready  = !r_w_cap && !ARESET;
        if (r_aw_cap && r_w_cap) begin
          w_commit  = 1'b1;
          w_wst_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (r_bvalid && S_AXI_BREADY) begin
          w_bdone   = 1'b1;
          w_wst_nxt = WR_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_rst_nxt = r_rst;
    w_arready = 1'b0;
    w_ar_acc  = 1'b0;
    unique case (r_rst)
      RD_IDLE: begin
        w_arready = !ARESET;
        if (S_AXI_ARVALID && !ARESET) begin
          w_ar_acc  = 1'b1;
          w_rst_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (S_AXI_RREADY) w_rst_nxt = RD_IDLE;
      end
    endcase
  end

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_aridx == IW'(i)) w_rd_word = r_regs[i];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wst    <= WR_IDLE;
      r_rst    <= RD_IDLE;
      r_aw_cap <= 1'b0;
      r_w_cap  <= 1'b0;
      r_awidx  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
      r_rvalid <= 1'b0;
      r_rresp  <= 2'b00;
      r_rdata  <= '0;
      r_wr_stb <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wst    <= w_wst_nxt;
      r_rst    <= w_rst_nxt;
      r_wr_stb <= '0;
      if (S_AXI_AWVALID && w_awready) begin
        r_aw_cap <= 1'b1;
        r_awidx  <= w_awidx;
      end
      if (S_AXI_WVALID && w_wready) begin
        r_w_cap <= 1'b1;
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_widx_ok ? 2'b00 : 2'b10;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_widx_ok && r_awidx == IW'(i)) begin
            r_wr_stb[i] <= 1'b1;
            for (int b = 0; b < NB; b++)
              if (r_wstrb[b])
                r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
      if (w_bdone) begin
        r_bvalid <= 1'b0;
        r_aw_cap <= 1'b0;
        r_w_cap  <= 1'b0;
      end
      // Read samples registers before any same-edge write lands.
      if (w_ar_acc) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_ridx_ok ? w_rd_word : '0;
        r_rresp  <= w_ridx_ok ? 2'b00 : 2'b10;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    assign reg_out[DW*gi +: DW] = r_regs[gi];
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign reg_wr_stb    = r_wr_stb;

endmodule

// File: tb/tb_hi_speed_sampler_s_axi_regs.sv
// Bench for hi_speed_sampler_s_axi_regs: scoreboarded AXI4-Lite
// transfers against a register model, one task per scenario.
module tb_hi_speed_sampler_s_axi_regs;

  localparam int TMO = 50;

  logic         ACLK;
  logic         ARESET;
  logic [4:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [4:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_stb;

  hi_speed_sampler_s_axi_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_wr_stb(reg_wr_stb)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [4];
  logic [5:0]  q_b [$];   // {stb, bresp}
  logic [33:0] q_r [$];   // {rresp, rdata}

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    q_b.delete();
    q_r.delete();
  endfunction

  function automatic logic [5:0] model_write(
    input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [2:0] idx;
    logic [3:0] stb;
    idx = a[4:2];
    stb = '0;
    if (idx < 3'd4) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_regs[idx[1:0]][8*b +: 8] = d[8*b +: 8];
      stb[idx[1:0]] = 1'b1;
      return {stb, 2'b00};
    end
    return {4'b0000, 2'b10};
  endfunction

  function automatic logic [33:0] model_read(input logic [4:0] a);
    logic [2:0] idx;
    idx = a[4:2];
    if (idx < 3'd4) return {2'b00, m_regs[idx[1:0]]};
    return {2'b10, 32'h0};
  endfunction

  function automatic logic [127:0] model_out();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  task automatic aw_send(input logic [4:0] a);
    S_AXI_AWADDR  = a;
    S_AXI_AWVALID = 1'b1;
    for (int n = 0; ; n++) begin
      if (S_AXI_AWREADY) begin
        @(posedge ACLK); #1;
        break;
      end
      if (n == TMO) begin
        vectors++; miscompares++;
        $display("FAIL aw_timeout awready=%b required=1", S_AXI_AWREADY);
        break;
      end
      @(posedge ACLK); #1;
    end
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = s;
    S_AXI_WVALID = 1'b1;
    for (int n = 0; ; n++) begin
      if (S_AXI_WREADY) begin
        @(posedge ACLK); #1;
        break;
      end
      if (n == TMO) begin
        vectors++; miscompares++;
        $display("FAIL w_timeout wready=%b required=1", S_AXI_WREADY);
        break;
      end
      @(posedge ACLK); #1;
    end
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [4:0] a);
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    for (int n = 0; ; n++) begin
      if (S_AXI_ARREADY) begin
        @(posedge ACLK); #1;
        break;
      end
      if (n == TMO) begin
        vectors++; miscompares++;
        $display("FAIL ar_timeout arready=%b required=1", S_AXI_ARREADY);
        break;
      end
      @(posedge ACLK); #1;
    end
    S_AXI_ARVALID = 1'b0;
  endtask

  task automatic b_recv(input bit chk_stb);
    logic [5:0] e;
    S_AXI_BREADY = 1'b1;
    for (int n = 0; ; n++) begin
      if (S_AXI_BVALID) begin
        vectors++;
        if (q_b.size() == 0) begin
          miscompares++;
          $display("FAIL b_unexpected bresp=%b required=none", S_AXI_BRESP);
        end else begin
          e = q_b.pop_front();
          if (S_AXI_BRESP !== e[1:0]) begin
            miscompares++;
            $display("FAIL bresp got=%b required=%b", S_AXI_BRESP, e[1:0]);
          end
          if (chk_stb) begin
            vectors++;
            if (reg_wr_stb !== e[5:2]) begin
              miscompares++;
              $display("FAIL wr_stb got=%b required=%b", reg_wr_stb, e[5:2]);
            end
          end
        end
        @(posedge ACLK); #1;
        break;
      end
      if (n == TMO) begin
        vectors++; miscompares++;
        $display("FAIL b_timeout bvalid=%b required=1", S_AXI_BVALID);
        break;
      end
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic r_recv();
    logic [33:0] e;
    S_AXI_RREADY = 1'b1;
    for (int n = 0; ; n++) begin
      if (S_AXI_RVALID) begin
        vectors++;
        if (q_r.size() == 0) begin
          miscompares++;
          $display("FAIL r_unexpected rdata=%h required=none", S_AXI_RDATA);
        end else begin
          e = q_r.pop_front();
          if ({S_AXI_RRESP, S_AXI_RDATA} !== e) begin
            miscompares++;
            $display("FAIL rdata got=%b_%h required=%b_%h",
                     S_AXI_RRESP, S_AXI_RDATA, e[33:32], e[31:0]);
          end
        end
        @(posedge ACLK); #1;
        break;
      end
      if (n == TMO) begin
        vectors++; miscompares++;
        $display("FAIL r_timeout rvalid=%b required=1", S_AXI_RVALID);
        break;
      end
      @(posedge ACLK); #1;
    end
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    q_b.push_back(model_write(a, d, s));
    fork
      aw_send(a);
      w_send(d, s);
    join
    b_recv(1'b1);
  endtask

  task automatic do_read(input logic [4:0] a);
    q_r.push_back(model_read(a));
    ar_send(a);
    r_recv();
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_ready got=%b%b%b required=000",
               S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
    end
    vectors++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP,
         S_AXI_RDATA, reg_wr_stb} !== '0) begin
      miscompares++;
      $display("FAIL rst_outs bv=%b rv=%b br=%b rr=%b rd=%h stb=%b required=0",
               S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP,
               S_AXI_RDATA, reg_wr_stb);
    end
    vectors++;
    if (reg_out !== model_out()) begin
      miscompares++;
      $display("FAIL rst_regs got=%h required=%h", reg_out, model_out());
    end
    ARESET = 1'b0;
    #1;
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      miscompares++;
      $display("FAIL post_rst_ready got=%b%b%b required=111",
               S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
    end
  endtask

  task automatic test_seq_rw();
    for (int i = 0; i < 4; i++)
      do_write(5'(4*i), 32'(i+1), 4'hF);
    for (int i = 0; i < 4; i++)
      do_read(5'(4*i));
    vectors++;
    if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
      miscompares++;
      $display("FAIL seq_regout got=%h required=%h", reg_out,
               128'h00000004_00000003_00000002_00000001);
    end
  endtask

  task automatic test_byte_strobes();
    do_write(5'h04, 32'hAABBCCDD, 4'hF);
    do_write(5'h05, 32'h11223344, 4'b0101);
    vectors++;
    if (reg_wr_stb !== 4'b0000) begin
      miscompares++;
      $display("FAIL stb_width got=%b required=0000", reg_wr_stb);
    end
    vectors++;
    if (reg_out[63:32] !== 32'hAA22CC44) begin
      miscompares++;
      $display("FAIL strb_reg1 got=%h required=AA22CC44", reg_out[63:32]);
    end
    do_write(5'h04, 32'hFFFFFFFF, 4'h0);
    do_read(5'h04);
    vectors++;
    if (reg_out !== model_out()) begin
      miscompares++;
      $display("FAIL strb_regs got=%h required=%h", reg_out, model_out());
    end
  endtask

  task automatic skew_one(input bit w_first, input logic [31:0] d);
    logic [5:0] e;
    e = model_write(5'h0C, d, 4'hF);
    q_b.push_back(e);
    if (w_first) w_send(d, 4'hF);
    else aw_send(5'h0C);
    repeat (3) begin
      vectors++;
      if (S_AXI_BVALID !== 1'b0 ||
          (w_first ? S_AXI_WREADY : S_AXI_AWREADY) !== 1'b0) begin
        miscompares++;
        $display("FAIL skew_gap bvalid=%b aw=%b w=%b required=0",
                 S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
      end
      @(posedge ACLK); #1;
    end
    if (w_first) aw_send(5'h0C);
    else w_send(d, 4'hF);
    vectors++;
    if (S_AXI_BVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL skew_early bvalid=%b required=0", S_AXI_BVALID);
    end
    @(posedge ACLK); #1;
    vectors++;
    if (S_AXI_BVALID !== 1'b1 || reg_wr_stb !== e[5:2]) begin
      miscompares++;
      $display("FAIL skew_lat bvalid=%b stb=%b required=1 %b",
               S_AXI_BVALID, reg_wr_stb, e[5:2]);
    end
    repeat (5) begin
      vectors++;
      if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}
          !== 5'b1_00_00) begin
        miscompares++;
        $display("FAIL skew_hold bv=%b br=%b aw=%b w=%b required=1 00 0 0",
                 S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY);
      end
      @(posedge ACLK); #1;
    end
    b_recv(1'b0);
    vectors++;
    if (reg_out !== model_out()) begin
      miscompares++;
      $display("FAIL skew_regs got=%h required=%h", reg_out, model_out());
    end
  endtask

  task automatic test_skewed();
    skew_one(1'b1, 32'hCAFE0001);
    skew_one(1'b0, 32'h0BAD0002);
  endtask

  task automatic test_decode_err();
    do_write(5'h10, 32'hDEADBEEF, 4'hF);
    vectors++;
    if (reg_out !== model_out()) begin
      miscompares++;
      $display("FAIL dec_regs got=%h required=%h", reg_out, model_out());
    end
    do_read(5'h14);
    do_read(5'h1F);
  endtask

  task automatic test_concurrent();
    do_write(5'h08, 32'h33, 4'hF);
    q_r.push_back(model_read(5'h08));
    q_b.push_back(model_write(5'h08, 32'h55, 4'hF));
    fork
      aw_send(5'h08);
      w_send(32'h55, 4'hF);
      ar_send(5'h08);
    join
    fork
      b_recv(1'b1);
      r_recv();
    join
    do_read(5'h08);
  endtask

  task automatic test_reset_mid();
    fork
      aw_send(5'h04);
      w_send(32'h99, 4'hF);
      ar_send(5'h00);
    join
    @(posedge ACLK); #1;
    vectors++;
    if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_pending bv=%b rv=%b required=11",
               S_AXI_BVALID, S_AXI_RVALID);
    end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    model_clear();
    vectors++;
    if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00 || reg_out !== model_out()) begin
      miscompares++;
      $display("FAIL mid_reset bv=%b rv=%b regs=%h required=0 0 0",
               S_AXI_BVALID, S_AXI_RVALID, reg_out);
    end
    ARESET = 1'b0;
    #1;
    do_write(5'h04, 32'h7, 4'hF);
    do_read(5'h04);
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    model_clear();
    test_reset();
    test_seq_rw();
    test_byte_strobes();
    test_skewed();
    test_decode_err();
    test_concurrent();
    test_reset_mid();
    vectors++;
    if (q_b.size() != 0 || q_r.size() != 0) begin
      miscompares++;
      $display("FAIL leftover b=%0d r=%0d required=0 0", q_b.size(), q_r.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
